cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) / PRF write port among the ALU, MEM and BR functional units.
- Each FU presents one completion per cycle over a valid/ready handshake.
- Each cycle the arbiter grants the oldest request, using ROB age relative to rob_head, with a starvation override. The winner is broadcast on a registered CDB output to the PRF, ROB and reservation stations.
- Completions younger than a branch mispredict are accepted and discarded.

Parameters:
- ROB_DEPTH, 32, ROB entries; power of 2; TAG_W = log2(ROB_DEPTH).
- PREG_W, 7, physical register index width.
- DATA_W, 32, result data width.
- STARVE_LIMIT, 8, wait cycles after which a requester is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rob_head  in  TAG_W  tag of the oldest ROB entry.
- flush  in  1  mispredict pulse.
- flush_tag  in  TAG_W  tag of the mispredicting branch.
- alu_valid/mem_valid/br_valid  in  1 each  FU completion valid.
- alu_ready/mem_ready/br_ready  out  1 each  completion accepted this cycle.
- alu_tag/mem_tag/br_tag  in  TAG_W each  ROB tag.
- alu_pd/mem_pd/br_pd  in  PREG_W each  destination physical register.
- alu_data/mem_data/br_data  in  DATA_W each  result.
- alu_we/mem_we/br_we  in  1 each  result writes the PRF; 0 for stores/branches without rd.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast ROB tag.
- cdb_pd  out  PREG_W  broadcast physical register.
- cdb_data  out  DATA_W  broadcast data.
- cdb_we  out  1  PRF write enable; equals cdb_valid & winner's we.
- cdb_src  out  2  winner source: 0=ALU, 1=MEM, 2=BR.

Behaviour:
- Reset (async): all cdb_* = 0, wait counters = 0.
  - *_ready are combinational and evaluate to 0 while reset is high.
- Age: age(t) = (t - rob_head) mod ROB_DEPTH; smaller age means older.
- Arbitration (combinational, same cycle as request):
  - If any valid requester has wait counter >= STARVE_LIMIT, it wins; ties go ALU > MEM > BR.
  - Otherwise the valid requester with the smallest age wins. Equal tags are illegal; if they occur, the tie breaks ALU > MEM > BR.
  - Only the winner sees ready=1. Losers hold their payload stable (valid/ready rule) and may not drop valid.
- Output latency: the winner's payload is registered and appears on cdb_* the next cycle for exactly one cycle.
  - With no winner, cdb_valid = 0 next cycle; the payload holds its last value (don't-care).
- Throughput: one broadcast per cycle; never backpressured by the CDB consumers.
- Wait counters, per requester:
  - Increment when valid & !ready.
  - Clear when ready or !valid.
  - Saturate at STARVE_LIMIT.
- Flush cycle (flush=1):
  - Every valid requester with age(tag) > age(flush_tag) gets ready=1 in the same cycle (killed, not broadcast) and its wait counter clears.
  - Arbitration runs among the surviving requesters only; the branch itself (age == flush_tag) survives.
  - A CDB entry already registered (visible this cycle) is not retracted.
- rob_head wrap: the age arithmetic is modular, so tags 30, 31, 0, 1 with rob_head=30 order correctly.
- No pending state beyond the output register and counters; reset mid-operation drops any in-flight broadcast.

Test Plan:
- Single request: alu_valid=1, tag=3, pd=12, data=0xDEAD_BEEF, we=1, rob_head=0 -> alu_ready=1 same cycle; next cycle cdb_valid=1, tag=3, pd=12, data=0xDEADBEEF, cdb_we=1, src=0; the following cycle cdb_valid=0.
- Age priority: rob_head=0, ALU tag=5, MEM tag=2, BR tag=9, all held valid -> broadcast order MEM(2), ALU(5), BR(9) on three consecutive cycles; losers' payload stays stable.
- Wrap-around: rob_head=30, ALU tag=1, BR tag=31 -> BR broadcast first, then ALU.
- Starvation: rob_head=0; ALU held valid with tag=20; MEM presents a fresh older tag (0..7, rotating) every cycle -> after 8 losing cycles ALU wins on the 9th, then its counter resets.
- Flush: rob_head=0, flush=1, flush_tag=4; ALU tag=6, MEM tag=3, BR tag=4 -> alu_ready=1 with ALU dropped; MEM (tag 3) broadcast next cycle; BR tag 4 broadcast the cycle after; no tag-6 broadcast ever appears.
- Reset mid-operation: assert reset while cdb_valid=1 and two requesters pend -> cdb_valid=0 immediately (async); after release, counters = 0 and arbitration restarts by age.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB arbiter: picks one FU completion per cycle (oldest ROB age, with a starvation
// override), discards completions killed by a mispredict, and registers the winner.
module cdb_arbiter #(
   parameter int unsigned ROB_DEPTH    = 32,
   parameter int unsigned PREG_W       = 7,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 8,
   localparam int unsigned TAG_W       = $clog2(ROB_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [TAG_W-1:0]  rob_head,
   input  logic              flush,
   input  logic [TAG_W-1:0]  flush_tag,
   input  logic              alu_valid,
   input  logic              mem_valid,
   input  logic              br_valid,
   output logic              alu_ready,
   output logic              mem_ready,
   output logic              br_ready,
   input  logic [TAG_W-1:0]  alu_tag,
   input  logic [TAG_W-1:0]  mem_tag,
   input  logic [TAG_W-1:0]  br_tag,
   input  logic [PREG_W-1:0] alu_pd,
   input  logic [PREG_W-1:0] mem_pd,
   input  logic [PREG_W-1:0] br_pd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] br_data,
   input  logic              alu_we,
   input  logic              mem_we,
   input  logic              br_we,
   output logic              cdb_valid,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic [PREG_W-1:0] cdb_pd,
   output logic [DATA_W-1:0] cdb_data,
   output logic              cdb_we,
   output logic [1:0]        cdb_src
);

   localparam int unsigned N     = 3;
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic              req_v    [N];
   logic [TAG_W-1:0]  req_tag  [N];
   logic [PREG_W-1:0] req_pd   [N];
   logic [DATA_W-1:0] req_data [N];
   logic              req_we   [N];

   assign req_v[0]    = alu_valid;
   assign req_v[1]    = mem_valid;
   assign req_v[2]    = br_valid;
   assign req_tag[0]  = alu_tag;
   assign req_tag[1]  = mem_tag;
   assign req_tag[2]  = br_tag;
   assign req_pd[0]   = alu_pd;
   assign req_pd[1]   = mem_pd;
   assign req_pd[2]   = br_pd;
   assign req_data[0] = alu_data;
   assign req_data[1] = mem_data;
   assign req_data[2] = br_data;
   assign req_we[0]   = alu_we;
   assign req_we[1]   = mem_we;
   assign req_we[2]   = br_we;

   logic [CNT_W-1:0]  wait_q [N];
   logic [CNT_W-1:0]  wait_d [N];
   logic [N-1:0]      kill;
   logic [N-1:0]      rdy;
   logic              win_v;
   logic [1:0]        win_idx;
   logic              found_starve;
   logic [TAG_W-1:0]  flush_age;
   logic [TAG_W-1:0]  best_age;
   logic [TAG_W-1:0]  cur_age;

   logic              cdb_valid_q;
   logic [TAG_W-1:0]  cdb_tag_q;
   logic [PREG_W-1:0] cdb_pd_q;
   logic [DATA_W-1:0] cdb_data_q;
   logic              cdb_we_q;
   logic [1:0]        cdb_src_q;

   // Ages are tag - rob_head in TAG_W bits, so the subtraction wraps modulo ROB_DEPTH.
   always_comb begin
      win_v        = 1'b0;
      win_idx      = '0;
      kill         = '0;
      rdy          = '0;
      found_starve = 1'b0;
      best_age     = '0;
      cur_age      = '0;
      flush_age    = flush_tag - rob_head;
      for (int unsigned i = 0; i < N; i++) begin
         cur_age = req_tag[i] - rob_head;
         kill[i] = flush & req_v[i] & (cur_age > flush_age);
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (req_v[i] && !kill[i] && !found_starve &&
             (wait_q[i] >= CNT_W'(STARVE_LIMIT))) begin
            found_starve = 1'b1;
            win_v        = 1'b1;
            win_idx      = 2'(i);
         end
      end
      if (!found_starve) begin
         for (int unsigned i = 0; i < N; i++) begin
            cur_age = req_tag[i] - rob_head;
            if (req_v[i] && !kill[i] && (!win_v || (cur_age < best_age))) begin
               win_v    = 1'b1;
               win_idx  = 2'(i);
               best_age = cur_age;
            end
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         rdy[i]    = ~reset & (kill[i] | (win_v & (win_idx == 2'(i))));
         wait_d[i] = '0;
         if (req_v[i] && !rdy[i]) begin
            wait_d[i] = (wait_q[i] >= CNT_W'(STARVE_LIMIT)) ? wait_q[i] : wait_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_pd_q    <= '0;
         cdb_data_q  <= '0;
         cdb_we_q    <= 1'b0;
         cdb_src_q   <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            wait_q[i] <= '0;
         end
      end else begin
         cdb_valid_q <= win_v;
         cdb_we_q    <= win_v & req_we[win_idx];
         if (win_v) begin
            cdb_tag_q  <= req_tag[win_idx];
            cdb_pd_q   <= req_pd[win_idx];
            cdb_data_q <= req_data[win_idx];
            cdb_src_q  <= win_idx;
         end
         for (int unsigned i = 0; i < N; i++) begin
            wait_q[i] <= wait_d[i];
         end
      end
   end

   assign alu_ready = rdy[0];
   assign mem_ready = rdy[1];
   assign br_ready  = rdy[2];

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_pd    = cdb_pd_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_we    = cdb_we_q;
   assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations plus a
// per-cycle reference model of age/starvation/flush arbitration.
module tb_cdb_arbiter;

   localparam int D      = 32;
   localparam int STARVE = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rob_head;
   logic        flush;
   logic [4:0]  flush_tag;
   logic        fv   [3];
   logic [4:0]  ft   [3];
   logic [6:0]  fpd  [3];
   logic [31:0] fd   [3];
   logic        fwe  [3];

   logic        alu_ready, mem_ready, br_ready;
   logic        cdb_valid, cdb_we;
   logic [4:0]  cdb_tag;
   logic [6:0]  cdb_pd;
   logic [31:0] cdb_data;
   logic [1:0]  cdb_src;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.ROB_DEPTH(32), .PREG_W(7), .DATA_W(32), .STARVE_LIMIT(8)) dut (
      .clk(clk), .reset(reset), .rob_head(rob_head), .flush(flush), .flush_tag(flush_tag),
      .alu_valid(fv[0]), .mem_valid(fv[1]), .br_valid(fv[2]),
      .alu_ready(alu_ready), .mem_ready(mem_ready), .br_ready(br_ready),
      .alu_tag(ft[0]), .mem_tag(ft[1]), .br_tag(ft[2]),
      .alu_pd(fpd[0]), .mem_pd(fpd[1]), .br_pd(fpd[2]),
      .alu_data(fd[0]), .mem_data(fd[1]), .br_data(fd[2]),
      .alu_we(fwe[0]), .mem_we(fwe[1]), .br_we(fwe[2]),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_pd(cdb_pd),
      .cdb_data(cdb_data), .cdb_we(cdb_we), .cdb_src(cdb_src)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   int          mcnt [3];
   bit          seen_rdy [3];
   bit          exp_v, exp_we;
   logic [4:0]  exp_tag;
   logic [6:0]  exp_pd;
   logic [31:0] exp_data;
   int          exp_src;

   always @(negedge clk) begin
      int age [3];
      int fage, best, bestkey, key;
      bit kill [3];
      bit mr [3];
      if (reset === 1'b1) begin
         check("rst_cdb_valid", cdb_valid, 0);
         check("rst_cdb_we", cdb_we, 0);
         check("rst_cdb_tag", cdb_tag, 0);
         check("rst_cdb_pd", cdb_pd, 0);
         check("rst_cdb_data", cdb_data, 0);
         check("rst_cdb_src", cdb_src, 0);
         check("rst_ready", {alu_ready, mem_ready, br_ready}, 0);
         for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            seen_rdy[i] = 0;
         end
         exp_v = 0;
         exp_we = 0;
      end else if (reset === 1'b0) begin
         check("cdb_valid", cdb_valid, exp_v);
         check("cdb_we", cdb_we, exp_we);
         if (exp_v) begin
            check("cdb_tag", cdb_tag, exp_tag);
            check("cdb_pd", cdb_pd, exp_pd);
            check("cdb_data", cdb_data, exp_data);
            check("cdb_src", cdb_src, exp_src);
         end
         fage = (int'(flush_tag) - int'(rob_head) + D) % D;
         best = -1;
         bestkey = 1 << 30;
         for (int i = 0; i < 3; i++) begin
            age[i]  = (int'(ft[i]) - int'(rob_head) + D) % D;
            kill[i] = flush && fv[i] && (age[i] > fage);
            if (fv[i] && !kill[i]) begin
               // starving requesters outrank everyone, ordered by FU only
               key = (mcnt[i] >= STARVE) ? i : 1000 + 3 * age[i] + i;
               if (key < bestkey) begin
                  bestkey = key;
                  best = i;
               end
            end
         end
         for (int i = 0; i < 3; i++) mr[i] = kill[i] || (best == i);
         check("alu_ready", alu_ready, mr[0]);
         check("mem_ready", mem_ready, mr[1]);
         check("br_ready", br_ready, mr[2]);
         for (int i = 0; i < 3; i++) begin
            seen_rdy[i] = mr[i];
            if (fv[i] && !mr[i]) mcnt[i] = (mcnt[i] < STARVE) ? mcnt[i] + 1 : STARVE;
            else mcnt[i] = 0;
         end
         exp_v = (best >= 0);
         if (best >= 0) begin
            exp_tag  = ft[best];
            exp_pd   = fpd[best];
            exp_data = fd[best];
            exp_src  = best;
            exp_we   = fwe[best];
         end else begin
            exp_we = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int i, input logic v, input logic [4:0] t, input logic [6:0] pd,
                      input logic [31:0] d, input logic we);
      fv[i] = v; ft[i] = t; fpd[i] = pd; fd[i] = d; fwe[i] = we;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; rob_head = '0; flush = 1'b0; flush_tag = '0;
      for (int i = 0; i < 3; i++) req(i, 1'b0, '0, '0, '0, 1'b0);
      #1 reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();

      // Single request
      req(0, 1'b1, 5'd3, 7'd12, 32'hDEAD_BEEF, 1'b1);
      #1 check("single_ready", alu_ready, 1);
      tick(); fv[0] = 1'b0;
      #1;
      check("single_valid", cdb_valid, 1);
      check("single_tag", cdb_tag, 3);
      check("single_pd", cdb_pd, 12);
      check("single_data", cdb_data, 32'hDEADBEEF);
      check("single_we", cdb_we, 1);
      check("single_src", cdb_src, 0);
      tick();
      #1 check("single_gap", cdb_valid, 0);

      // Age priority
      req(0, 1'b1, 5'd5, 7'd20, 32'h0000_0A5A, 1'b1);
      req(1, 1'b1, 5'd2, 7'd21, 32'h0000_1111, 1'b0);
      req(2, 1'b1, 5'd9, 7'd22, 32'h0000_2222, 1'b1);
      #1 check("age_rdy0", {alu_ready, mem_ready, br_ready}, 3'b010);
      tick(); fv[1] = 1'b0;
      #1;
      check("age_first_tag", cdb_tag, 2);
      check("age_first_we", cdb_we, 0);
      check("age_rdy1", {alu_ready, mem_ready, br_ready}, 3'b100);
      tick(); fv[0] = 1'b0;
      #1;
      check("age_second_tag", cdb_tag, 5);
      check("age_rdy2", {alu_ready, mem_ready, br_ready}, 3'b001);
      tick(); fv[2] = 1'b0;
      #1;
      check("age_third_tag", cdb_tag, 9);
      check("age_third_src", cdb_src, 2);
      tick();

      // Wrap-around
      rob_head = 5'd30;
      req(0, 1'b1, 5'd1, 7'd30, 32'h0000_0001, 1'b1);
      req(2, 1'b1, 5'd31, 7'd31, 32'h0000_0031, 1'b1);
      #1 check("wrap_rdy", {alu_ready, mem_ready, br_ready}, 3'b001);
      tick(); fv[2] = 1'b0;
      #1;
      check("wrap_first", cdb_tag, 31);
      check("wrap_rdy2", alu_ready, 1);
      tick(); fv[0] = 1'b0;
      #1 check("wrap_second", cdb_tag, 1);
      tick();

      // Starvation
      rob_head = 5'd0;
      req(0, 1'b1, 5'd20, 7'd40, 32'h0000_0020, 1'b1);
      for (int c = 0; c < 10; c++) begin
         req(1, 1'b1, 5'(c % 8), 7'(50 + c), 32'(100 + c), 1'b1);
         if (c == 9) req(0, 1'b1, 5'd21, 7'd41, 32'h0000_0021, 1'b1);
         #1;
         if (c == 8) check("starve_win", {alu_ready, mem_ready}, 2'b10);
         else check("starve_lose", {alu_ready, mem_ready}, 2'b01);
         tick();
         if (c == 8) check("starve_tag", cdb_tag, 20);
      end
      fv[1] = 1'b0;
      #1 check("starve_reset_cnt", alu_ready, 1);
      tick(); fv[0] = 1'b0;
      tick();

      // Flush
      flush = 1'b1; flush_tag = 5'd4;
      req(0, 1'b1, 5'd6, 7'd60, 32'h0000_0006, 1'b1);
      req(1, 1'b1, 5'd3, 7'd61, 32'h0000_0003, 1'b1);
      req(2, 1'b1, 5'd4, 7'd62, 32'h0000_0004, 1'b0);
      #1 check("flush_rdy", {alu_ready, mem_ready, br_ready}, 3'b110);
      tick();
      flush = 1'b0; fv[0] = 1'b0; fv[1] = 1'b0;
      #1;
      check("flush_first", cdb_tag, 3);
      check("flush_br_rdy", br_ready, 1);
      tick(); fv[2] = 1'b0;
      #1;
      check("flush_second", cdb_tag, 4);
      check("flush_second_src", cdb_src, 2);
      tick();
      #1 check("flush_idle", cdb_valid, 0);

      // Reset mid-operation
      req(0, 1'b1, 5'd7, 7'd70, 32'h0000_0007, 1'b1);
      req(1, 1'b1, 5'd3, 7'd71, 32'h0000_0003, 1'b1);
      req(2, 1'b1, 5'd9, 7'd72, 32'h0000_0009, 1'b1);
      tick(); fv[1] = 1'b0;
      #1 check("rmid_pre", cdb_valid, 1);
      reset = 1'b1;
      #1;
      check("rmid_async", cdb_valid, 0);
      check("rmid_rdy", {alu_ready, br_ready}, 2'b00);
      tick();
      reset = 1'b0;
      #1 check("rmid_restart", {alu_ready, br_ready}, 2'b10);
      tick(); fv[0] = 1'b0;
      #1 check("rmid_first", cdb_tag, 7);
      tick(); fv[2] = 1'b0;
      #1 check("rmid_second", cdb_tag, 9);
      tick();

      // Mixed traffic obeying the handshake; tags per FU are distinct by residue mod 3
      for (int c = 0; c < 300; c++) begin
         if (c % 20 == 0) rob_head = 5'($urandom_range(0, 31));
         flush = ($urandom_range(0, 15) == 0);
         flush_tag = 5'(int'(rob_head) + int'($urandom_range(0, 31)));
         for (int i = 0; i < 3; i++) begin
            if (!fv[i] || seen_rdy[i]) begin
               if ($urandom_range(0, 3) != 0)
                  req(i, 1'b1, 5'(i + 3 * int'($urandom_range(0, 9))), 7'($urandom),
                      $urandom, 1'($urandom));
               else
                  fv[i] = 1'b0;
            end
         end
         tick();
      end
      flush = 1'b0;
      for (int i = 0; i < 3; i++) fv[i] = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
